// File: rtl/multi_tone_divider_pkg.sv
// Shared types and constants for the multi-channel tone generator and its
// time-shared divider.
package multi_tone_divider_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    localparam int unsigned FW_DEFAULT  = 32;
    localparam int unsigned DVW_DEFAULT = FW_DEFAULT + 1;

    // The divisor is 2*freq, so it needs one bit more than the frequency.
    function automatic int unsigned divisor_width(input int unsigned fw);
        return fw + 1;
    endfunction

endpackage

// File: rtl/multi_tone_divider_seq_udiv.sv
// Restoring unsigned divider: W-bit dividend over a (W+1)-bit divisor, one
// quotient bit per cycle, with a start/busy/done handshake.
module seq_udiv
    import multi_tone_divider_pkg::*;
#(
    parameter int unsigned W = FW_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W:0]   divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int unsigned CW = $clog2(W) + 1;

    div_state_t    state;
    div_state_t    state_next;
    logic [CW-1:0] iter;
    logic [W:0]    rem;
    logic [W-1:0]  q;
    logic [W:0]    dvs;
    logic [W+1:0]  shifted;
    logic [W+1:0]  diff;
    logic          take;

    // q doubles as the dividend shift register; its MSB feeds the remainder.
    assign shifted = {rem, q[W-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign take    = (shifted >= {1'b0, dvs});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = (state != DIV_IDLE);
        done       = (state == DIV_DONE);
        case (state)
            DIV_IDLE: if (start) state_next = DIV_RUN;
            DIV_RUN:  if (iter == CW'(W - 1)) state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter <= '0;
            rem  <= '0;
            q    <= '0;
            dvs  <= '0;
        end else if (state == DIV_IDLE && start) begin
            iter <= '0;
            rem  <= '0;
            q    <= dividend;
            dvs  <= divisor;
        end else if (state == DIV_RUN) begin
            rem  <= take ? diff[W:0] : shifted[W:0];
            q    <= {q[W-2:0], take};
            iter <= iter + 1'b1;
        end
    end

    assign quotient = q;

endmodule

// File: rtl/multi_tone_divider.sv
// N-channel square-wave generator: per-channel frequency capture, lowest-index
// arbitration onto one shared divider, and per-channel phase counters.
module multi_tone_divider
    import multi_tone_divider_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned CH     = 4,
    parameter int unsigned FW     = FW_DEFAULT
) (
    input  logic              CLOCK,
    input  logic              resetn,
    input  logic [CH*FW-1:0]  freq_in,
    input  logic [CH-1:0]     load,
    output logic [CH-1:0]     clk_out,
    output logic [CH-1:0]     valid,
    output logic              busy,
    output logic [CH*FW-1:0]  half_cnt_out
);

    localparam int unsigned   DW       = divisor_width(FW);
    localparam int unsigned   IW       = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [FW-1:0] DIVIDEND = FW'(CLK_HZ);

    logic [FW-1:0] freq_reg [CH];
    logic [FW-1:0] half_cnt [CH];
    logic [FW-1:0] phase    [CH];
    logic [CH-1:0] pending;
    logic [IW-1:0] cur;
    logic          abort;

    logic [IW-1:0] pick;
    logic          found;
    logic          start;
    logic          commit;
    logic [DW-1:0] divisor;
    logic          div_busy;
    logic          div_done;
    logic [FW-1:0] quot;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (pending[i] && !found) begin
                pick  = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign start   = found && !div_busy;
    assign divisor = {freq_reg[pick], 1'b0};
    // Any load landing on the served channel at completion also invalidates it.
    assign commit  = div_done && !abort && !load[cur];

    seq_udiv #(
        .W(FW)
    ) u_div (
        .clk      (CLOCK),
        .rst_n    (resetn),
        .start    (start),
        .dividend (DIVIDEND),
        .divisor  (divisor),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (quot)
    );

    assign busy = div_busy;

    always_ff @(posedge CLOCK or negedge resetn) begin
        if (!resetn) begin
            cur   <= '0;
            abort <= 1'b0;
        end else if (start) begin
            cur   <= pick;
            abort <= load[pick];
        end else if (div_busy && load[cur]) begin
            abort <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge resetn) begin
        if (!resetn) begin
            pending <= '0;
            valid   <= '0;
            clk_out <= '0;
            for (int unsigned i = 0; i < CH; i++) begin
                freq_reg[i] <= '0;
                half_cnt[i] <= '0;
                phase[i]    <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                if (load[i]) begin
                    freq_reg[i] <= freq_in[i*FW +: FW];
                    pending[i]  <= (freq_in[i*FW +: FW] != '0);
                end else if (start && pick == IW'(i)) begin
                    pending[i]  <= 1'b0;
                end

                if (load[i] && freq_in[i*FW +: FW] == '0) begin
                    valid[i]   <= 1'b0;
                    clk_out[i] <= 1'b0;
                    phase[i]   <= '0;
                end else if (commit && cur == IW'(i)) begin
                    half_cnt[i] <= (quot == '0) ? '0 : quot - FW'(1);
                    valid[i]    <= 1'b1;
                    phase[i]    <= '0;
                end else if (valid[i]) begin
                    if (phase[i] == half_cnt[i]) begin
                        phase[i]   <= '0;
                        clk_out[i] <= ~clk_out[i];
                    end else begin
                        phase[i]   <= phase[i] + FW'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        half_cnt_out = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            half_cnt_out[i*FW +: FW] = half_cnt[i];
        end
    end

endmodule

// File: tb/tb_multi_tone_divider.sv
// Self-checking bench for multi_tone_divider: directed scenarios plus a
// randomized phase against a frequency-to-half-count reference model.
module tb_multi_tone_divider;

    localparam int unsigned CLK = 1000000;
    localparam int unsigned NCH = 4;
    localparam int unsigned W   = 32;

    logic               CLOCK = 1'b0;
    logic               resetn;
    logic [NCH*W-1:0]   freq_in;
    logic [NCH-1:0]     load;
    logic [NCH-1:0]     clk_out;
    logic [NCH-1:0]     valid;
    logic               busy;
    logic [NCH*W-1:0]   half_cnt_out;

    int unsigned checks = 0;
    int unsigned passed = 0;
    int unsigned model_freq [NCH];

    multi_tone_divider #(
        .CLK_HZ(CLK),
        .CH    (NCH),
        .FW    (W)
    ) dut (
        .CLOCK        (CLOCK),
        .resetn       (resetn),
        .freq_in      (freq_in),
        .load         (load),
        .clk_out      (clk_out),
        .valid        (valid),
        .busy         (busy),
        .half_cnt_out (half_cnt_out)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    function automatic longint ref_half(input int unsigned f);
        longint q;
        if (f == 0) return 0;
        q = longint'(CLK) / (2 * longint'(f));
        return (q == 0) ? 0 : q - 1;
    endfunction

    function automatic longint half_of(input int unsigned ch);
        return longint'(half_cnt_out[ch*W +: W]);
    endfunction

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic set_ch(input int unsigned ch, input int unsigned f);
        freq_in[ch*W +: W] = f;
        load[ch]           = 1'b1;
        model_freq[ch]     = f;
    endtask

    task automatic pulse();
        step();
        load = '0;
    endtask

    // Full period of channel ch in cycles, -1 if three toggles never arrive.
    task automatic measure_period(input int unsigned ch, output int p);
        logic prev;
        int   nt;
        int   t0;
        prev = clk_out[ch];
        nt   = 0;
        t0   = 0;
        p    = -1;
        for (int n = 1; n <= 5000; n++) begin
            step();
            if (clk_out[ch] != prev) begin
                if (nt == 0) t0 = n;
                nt++;
                if (nt == 3) begin
                    p = n - t0;
                    break;
                end
            end
            prev = clk_out[ch];
        end
    endtask

    task automatic count_toggles(input int unsigned ch, input int cycles, output int nt);
        logic prev;
        prev = clk_out[ch];
        nt   = 0;
        for (int n = 0; n < cycles; n++) begin
            step();
            if (clk_out[ch] != prev) nt++;
            prev = clk_out[ch];
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        load   = '0;
        for (int unsigned i = 0; i < NCH; i++) model_freq[i] = 0;
        repeat (3) step();
        resetn = 1'b1;
        step();
    endtask

    initial begin
        int busy_cnt, vt, v0, v1, nt, p, nfinal, quiet, hi_cnt;
        int unsigned mask, ch, r, f;
        longint half_at34;

        freq_in = '0;
        load    = '0;
        resetn  = 1'b0;
        do_reset();

        check("rst_clk_out", clk_out, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_half", half_cnt_out == '0, 1);

        // Single channel: latency, busy length, half count, output period.
        set_ch(0, 1000);
        pulse();
        busy_cnt = 0;
        vt = 0;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (busy) busy_cnt++;
            if (valid[0] && vt == 0) vt = n;
        end
        check("t2_latency", vt, W + 2);
        check("t2_busy_cycles", busy_cnt, W + 1);
        check("t2_half", half_of(0), ref_half(1000));
        measure_period(0, p);
        check("t2_period", p, 1000);

        // Same-edge loads served lowest index first; next start waits one idle edge.
        set_ch(0, 250000);
        set_ch(1, 500000);
        pulse();
        v0 = 0;
        v1 = 0;
        for (int n = 1; n <= 120; n++) begin
            step();
            if (v0 == 0 && half_of(0) == ref_half(250000)) v0 = n;
            if (v1 == 0 && valid[1]) v1 = n;
        end
        check("t3_ch0_latency", v0, W + 2);
        check("t3_ch1_gap", v1 - v0, W + 2);
        check("t3_ch0_half", half_of(0), 1);
        check("t3_ch1_half", half_of(1), 0);
        count_toggles(1, 8, nt);
        check("t3_ch1_toggles", nt, 8);

        // Zero frequency stops a running channel at once.
        set_ch(2, 1000);
        pulse();
        for (int n = 0; n < 100 && !valid[2]; n++) step();
        check("t4_ch2_valid", valid[2], 1);
        check("t4_ch2_half", half_of(2), 499);
        repeat (250) step();
        set_ch(2, 0);
        pulse();
        check("t4_ch2_valid_off", valid[2], 0);
        check("t4_ch2_clk_low", clk_out[2], 0);
        hi_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (clk_out[2] || valid[2]) hi_cnt++;
        end
        check("t4_ch2_held_low", hi_cnt, 0);
        check("t4_ch0_undisturbed", {valid[0], half_of(0) == 1}, 2'b11);
        count_toggles(1, 4, nt);
        check("t4_ch1_toggles", nt, 4);

        // Saturation and minimum frequency.
        set_ch(3, 3000000);
        pulse();
        for (int n = 0; n < 100 && !valid[3]; n++) step();
        check("t5_sat_half", half_of(3), 0);
        count_toggles(3, 6, nt);
        check("t5_sat_toggles", nt, 6);
        set_ch(3, 1);
        pulse();
        for (int n = 0; n < 100 && half_of(3) == 0; n++) step();
        check("t5_min_half", half_of(3), ref_half(1));

        // Reload mid-computation: first result dropped, old output keeps running.
        set_ch(0, 1000);
        pulse();
        nt = 0;
        nfinal = 0;
        half_at34 = -1;
        begin
            logic prev;
            prev = clk_out[0];
            for (int n = 1; n <= 120; n++) begin
                step();
                if (n == 11) load = '0;
                if (n == 10) set_ch(0, 2000);
                if (n <= 60 && clk_out[0] != prev) nt++;
                prev = clk_out[0];
                if (n == W + 2) half_at34 = half_of(0);
                if (nfinal == 0 && half_of(0) == ref_half(2000)) nfinal = n;
            end
        end
        check("t6_discard", half_at34, 1);
        check("t6_old_toggles", nt, 30);
        check("t6_final_cycle", nfinal, 2 * (W + 2));
        check("t6_final_half", half_of(0), 249);

        // Reset in the middle of a computation.
        set_ch(1, 777);
        pulse();
        repeat (5) step();
        #2 resetn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_clk", clk_out, 0);
        check("mid_rst_half", half_cnt_out == '0, 1);
        for (int unsigned i = 0; i < NCH; i++) model_freq[i] = 0;
        repeat (3) step();
        resetn = 1'b1;
        repeat (50) step();
        check("post_rst_idle", {busy, valid}, 0);

        // Randomized loads against the reference model.
        for (int it = 0; it < 15; it++) begin
            mask = $urandom_range(1, 15);
            for (int unsigned i = 0; i < NCH; i++) begin
                if (mask[i]) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) f = 0;
                    else if (r == 1) f = $urandom_range(500001, 5000000);
                    else f = $urandom_range(1000, 600000);
                    set_ch(i, f);
                end
            end
            pulse();
            quiet = 0;
            for (int n = 0; n < 400 && quiet < 3; n++) begin
                step();
                if (!busy) quiet++;
                else quiet = 0;
            end
            check("rnd_settle", quiet >= 3, 1);
            for (int unsigned i = 0; i < NCH; i++) begin
                check($sformatf("rnd_valid%0d", i), valid[i], model_freq[i] != 0);
                if (model_freq[i] != 0)
                    check($sformatf("rnd_half%0d", i), half_of(i), ref_half(model_freq[i]));
            end
            ch = $urandom_range(0, NCH - 1);
            if (model_freq[ch] != 0) begin
                measure_period(ch, p);
                check($sformatf("rnd_period%0d", ch), p, 2 * (ref_half(model_freq[ch]) + 1));
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
